// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD timer controller: controller states,
// BCD digit constants and a digit clamp helper.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // A non-decimal nibble (A..F) behaves as the largest decimal digit.
  function automatic logic [3:0] clampDigit(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit: 4-bit modulo-10 counter with synchronous clear,
// count enable and a carry that fires when the digit rolls 9 -> 0.
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [3:0] value_o,
  output logic       carry_o
);

  logic [3:0] value_q, value_d;

  // Next digit value: clear dominates, otherwise advance and roll over at 9.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = BCD_ZERO;
    end else if (en_i) begin
      value_d = (value_q >= BCD_MAX) ? BCD_ZERO : value_q + 4'd1;
    end
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_q <= BCD_ZERO;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign carry_o = en_i && !clr_i && (value_q >= BCD_MAX);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD timer controller with start/stop/clear commands and a
// terminal-count done pulse. Optional lap capture register is built when
// the macro BCD_TIMER_LAP_EN is defined.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
  input  logic       tick_i,
  input  logic [7:0] limit_i,
`ifdef BCD_TIMER_LAP_EN
  input  logic       lap_req_i,
  output logic [7:0] lap_o,
`endif
  output logic [3:0] ones_o,
  output logic [3:0] tens_o,
  output logic       busy_o,
  output logic       done_o
);

  state_e     state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tickTaken;
  logic       countEn;
  logic       countClr;
  logic       onesCarry;
  logic       tensCarry;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [7:0] effLimit;
  logic       atLimit;

  // Both digits are valid BCD, so a plain binary compare orders them
  // correctly; ">=" also catches a limit lowered below the current count.
  assign effLimit = {clampDigit(limit_i[7:4]), clampDigit(limit_i[3:0])};
  assign atLimit  = {tens, ones} >= effLimit;

  // Command decode and next state: clear beats stop, stop beats start,
  // and a tick only counts where the timer is (or is becoming) running.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    tickTaken = 1'b0;
    countEn   = 1'b0;
    countClr  = 1'b0;
    if (clear_i) begin
      state_d  = IDLE;
      countClr = 1'b1;
    end else if (stop_i) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else begin
      unique case (state_q)
        IDLE:    if (start_i) state_d = RUN;
        RUN:     tickTaken = tick_i;
        PAUSE: begin
          if (start_i) begin
            state_d   = RUN;
            tickTaken = tick_i;
          end
        end
        DONE:    if (start_i) state_d = RUN;
        default: state_d = IDLE;
      endcase
      if (tickTaken) begin
        if (atLimit) begin
          countClr = 1'b1;
          done_d   = 1'b1;
          state_d  = AUTO_RELOAD ? RUN : DONE;
        end else begin
          countEn = 1'b1;
        end
      end
    end
    busy_d = (state_d == RUN) || (state_d == PAUSE);
  end

  // State and registered status flags; a tens rollover can only come from
  // a 99 terminal count, so it is folded into done as a backstop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d | tensCarry;
    end
  end

  bcd_digit u_ones (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (countEn),
    .clr_i   (countClr),
    .value_o (ones),
    .carry_o (onesCarry)
  );

  bcd_digit u_tens (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (onesCarry),
    .clr_i   (countClr),
    .value_o (tens),
    .carry_o (tensCarry)
  );

`ifdef BCD_TIMER_LAP_EN
  logic [7:0] lap_q;

  // Lap snapshot of the running count; cleared with the timer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lap_q <= 8'h00;
    end else if (clear_i) begin
      lap_q <= 8'h00;
    end else if (lap_req_i && ((state_q == RUN) || (state_q == PAUSE))) begin
      lap_q <= {tens, ones};
    end
  end

  assign lap_o = lap_q;
`endif

  assign ones_o = ones;
  assign tens_o = tens;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: vector table plus hand-written
// multi-cycle sequences, with a second instance built with AUTO_RELOAD=1.
module tb_bcd_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, clear, tick;
  logic [7:0] limit;
  logic [3:0] ones, tens, onesR, tensR;
  logic       busy, done, busyR, doneR;
`ifdef BCD_TIMER_LAP_EN
  logic       lapReq;
  logic [7:0] lap, lapR;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] count;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  typedef struct {
    logic       r, s, p, c, t;
    logic [7:0] lim;
    logic [7:0] count;
    logic       busy, done;
    string      name;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[14];

  bcd_timer_ctrl #(.AUTO_RELOAD(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .clear_i(clear), .tick_i(tick), .limit_i(limit),
`ifdef BCD_TIMER_LAP_EN
    .lap_req_i(lapReq), .lap_o(lap),
`endif
    .ones_o(ones), .tens_o(tens), .busy_o(busy), .done_o(done)
  );

  bcd_timer_ctrl #(.AUTO_RELOAD(1'b1)) dutReload (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .clear_i(clear), .tick_i(tick), .limit_i(limit),
`ifdef BCD_TIMER_LAP_EN
    .lap_req_i(lapReq), .lap_o(lapR),
`endif
    .ones_o(onesR), .tens_o(tensR), .busy_o(busyR), .done_o(doneR)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", nm, act, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue required one entry");
    end else begin
      e = expQ.pop_front();
      cmp({e.name, "_count"}, {tens, ones}, e.count);
      cmp({e.name, "_busy"}, {7'd0, busy}, {7'd0, e.busy});
      cmp({e.name, "_done"}, {7'd0, done}, {7'd0, e.done});
    end
  endtask

  task automatic checkReload(input string nm, input logic [7:0] cnt, input logic b, input logic d);
    cmp({nm, "_rl_count"}, {tensR, onesR}, cnt);
    cmp({nm, "_rl_busy"}, {7'd0, busyR}, {7'd0, b});
    cmp({nm, "_rl_done"}, {7'd0, doneR}, {7'd0, d});
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic c,
                               input logic t, input logic [7:0] lim, input logic [7:0] eCount,
                               input logic eBusy, input logic eDone, input string nm);
    rst_n = r; start = s; stop = p; clear = c; tick = t; limit = lim;
    expQ.push_back('{count: eCount, busy: eBusy, done: eDone, name: nm});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic step(input logic s, input logic p, input logic c, input logic t,
                      input logic [7:0] eCount, input logic eBusy, input logic eDone,
                      input string nm);
    applyStimulus(1'b1, s, p, c, t, limit, eCount, eBusy, eDone, nm);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; tick = 1'b0; limit = 8'h12;
`ifdef BCD_TIMER_LAP_EN
    lapReq = 1'b0;
`endif
    vecs[0]  = '{0,1,0,0,1, 8'h12, 8'h00, 0, 0, "reset_a"};
    vecs[1]  = '{0,1,0,0,0, 8'h12, 8'h00, 0, 0, "reset_b"};
    vecs[2]  = '{1,0,0,0,1, 8'h12, 8'h00, 0, 0, "idle_tick"};
    vecs[3]  = '{1,1,0,0,0, 8'h12, 8'h00, 1, 0, "start"};
    vecs[4]  = '{1,0,0,0,1, 8'h12, 8'h01, 1, 0, "tick1"};
    vecs[5]  = '{1,0,0,0,1, 8'h12, 8'h02, 1, 0, "tick2"};
    vecs[6]  = '{1,0,1,0,1, 8'h12, 8'h02, 1, 0, "stop_tick"};
    vecs[7]  = '{1,0,0,0,1, 8'h12, 8'h02, 1, 0, "pause_tick"};
    vecs[8]  = '{1,1,0,0,0, 8'h12, 8'h02, 1, 0, "resume"};
    vecs[9]  = '{1,0,0,0,1, 8'h12, 8'h03, 1, 0, "tick3"};
    vecs[10] = '{1,1,0,1,1, 8'h12, 8'h00, 0, 0, "clear_all"};
    vecs[11] = '{1,1,0,0,0, 8'h12, 8'h00, 1, 0, "restart"};
    vecs[12] = '{1,0,0,0,1, 8'h12, 8'h01, 1, 0, "tick_again"};
    vecs[13] = '{0,1,0,0,1, 8'h12, 8'h00, 0, 0, "reset_mid_run"};

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].t, vecs[i].lim,
                    vecs[i].count, vecs[i].busy, vecs[i].done, vecs[i].name);
    end

    $display("[TB] pause sequence");
    step(1, 0, 0, 0, 8'h00, 1, 0, "p_start");
    for (int k = 1; k <= 7; k++) step(0, 0, 0, 1, bcd(k), 1, 0, "p_count");
    step(0, 1, 0, 1, 8'h07, 1, 0, "p_stop_tick");
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 8'h07, 1, 0, "p_hold");
    step(1, 0, 0, 0, 8'h07, 1, 0, "p_resume");
    step(0, 0, 0, 1, 8'h08, 1, 0, "p_after");
    step(0, 0, 1, 0, 8'h00, 0, 0, "p_clear");

    $display("[TB] carry and clear sequence");
    step(1, 0, 0, 0, 8'h00, 1, 0, "c_start");
    for (int k = 1; k <= 9; k++) step(0, 0, 0, 1, bcd(k), 1, 0, "c_count");
    step(0, 0, 0, 1, 8'h10, 1, 0, "c_carry");
    step(1, 0, 1, 1, 8'h00, 0, 0, "c_clear_all");

    $display("[TB] terminal count 12");
    step(1, 0, 0, 0, 8'h00, 1, 0, "t_start");
    checkReload("t_start", 8'h00, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 1, bcd(k), 1, 0, "t_count");
      checkReload("t_count", bcd(k), 1, 0);
    end
    step(0, 0, 0, 1, 8'h00, 0, 1, "t_terminal");
    checkReload("t_terminal", 8'h00, 1, 1);
    for (int k = 1; k <= 13; k++) begin
      step(0, 0, 0, 1, 8'h00, 0, 0, "t_done_tick");
      checkReload("t_reload", (k == 13) ? 8'h00 : bcd(k), 1, (k == 13));
    end
    step(0, 0, 0, 0, 8'h00, 0, 0, "t_idle");

    $display("[TB] clamped limit FA");
    step(0, 0, 1, 0, 8'h00, 0, 0, "f_clear");
    limit = 8'hFA;
    step(1, 0, 0, 0, 8'h00, 1, 0, "f_start");
    for (int k = 1; k <= 99; k++) step(0, 0, 0, 1, bcd(k), 1, 0, "f_count");
    step(0, 0, 0, 1, 8'h00, 0, 1, "f_terminal");
    step(0, 0, 0, 1, 8'h00, 0, 0, "f_after");

    $display("[TB] limit 00");
    limit = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 8'h00, 1, 0, "z_start");
      step(0, 0, 0, 1, 8'h00, 0, 1, "z_tick");
      checkReload("z_tick", 8'h00, 1, 1);
    end

    $display("[TB] clamped ones digit 1A");
    step(0, 0, 1, 0, 8'h00, 0, 0, "o_clear");
    limit = 8'h1A;
    step(1, 0, 0, 0, 8'h00, 1, 0, "o_start");
    for (int k = 1; k <= 19; k++) step(0, 0, 0, 1, bcd(k), 1, 0, "o_count");
    step(0, 0, 0, 1, 8'h00, 0, 1, "o_terminal");

    $display("[TB] limit lowered below count");
    step(0, 0, 1, 0, 8'h00, 0, 0, "l_clear");
    limit = 8'h12;
    step(1, 0, 0, 0, 8'h00, 1, 0, "l_start");
    for (int k = 1; k <= 5; k++) step(0, 0, 0, 1, bcd(k), 1, 0, "l_count");
    limit = 8'h03;
    step(0, 0, 0, 1, 8'h00, 0, 1, "l_terminal");

`ifdef BCD_TIMER_LAP_EN
    $display("[TB] lap capture");
    step(0, 0, 1, 0, 8'h00, 0, 0, "lap_clear0");
    limit = 8'h99;
    step(1, 0, 0, 0, 8'h00, 1, 0, "lap_start");
    for (int k = 1; k <= 34; k++) step(0, 0, 0, 1, bcd(k), 1, 0, "lap_count");
    lapReq = 1'b1;
    step(0, 0, 0, 1, 8'h35, 1, 0, "lap_req");
    lapReq = 1'b0;
    cmp("lap_capture", lap, 8'h34);
    for (int k = 36; k <= 38; k++) begin
      step(0, 0, 0, 1, bcd(k), 1, 0, "lap_adv");
      cmp("lap_hold", lap, 8'h34);
    end
    step(0, 0, 1, 0, 8'h00, 0, 0, "lap_clear");
    cmp("lap_cleared", lap, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
